// File: rtl/traceback_unit.sv
// Viterbi survivor-path traceback for a 4-state trellis (s = {u_t, u_t-1}).
// Collects one block of DEPTH ACS steps, traces back from the best final state, then streams the bits forward.
module traceback_unit #(
    parameter int DEPTH = 16,
    parameter int PMW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [3:0]         sel_i,
    input  logic [4*PMW-1:0]   pm_i,
    output logic               in_ready,
    output logic               out_valid,
    output logic               out_bit,
    input  logic               out_ready,
    output logic               out_last
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRW-1:0] LAST_IDX = PTRW'(DEPTH - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        TRACE  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PTRW-1:0]   wr_ptr_r;
    logic [PTRW-1:0]   t_ptr_r;
    logic [PTRW-1:0]   bit_idx_r;
    logic [PTRW-1:0]   nxt_idx_s;
    logic [1:0]        cur_state_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_bit_r;
    logic              out_last_r;
    logic [3:0]        surv_mem_r [DEPTH];
    logic [DEPTH-1:0]  out_buf_r;

    logic              wr_fire_s;
    logic              fill_done_s;
    logic              trace_done_s;
    logic              out_fire_s;
    logic              out_done_s;
    logic              surv_bit_s;

    // Index of the cheapest lane; strict less-than keeps ties on the lowest index.
    function automatic logic [1:0] min_lane(input logic [4*PMW-1:0] pm);
        logic [1:0]     best;
        logic [PMW-1:0] best_pm;
        best    = 2'd0;
        best_pm = pm[0 +: PMW];
        for (int s = 1; s < 4; s++) begin
            if (pm[s*PMW +: PMW] < best_pm) begin
                best    = 2'(s);
                best_pm = pm[s*PMW +: PMW];
            end else begin
                best    = best;
            end
        end
        return best;
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_bit   = out_bit_r;
    assign out_last  = out_last_r;

    // Handshake qualifiers and the survivor bit selected by the current trellis state.
    always_comb begin
        wr_fire_s    = (state_r == FILL) && valid_i;
        fill_done_s  = wr_fire_s && (wr_ptr_r == LAST_IDX);
        trace_done_s = (state_r == TRACE) && (t_ptr_r == {PTRW{1'b0}});
        out_fire_s   = (state_r == OUTPUT) && out_valid_r && out_ready;
        out_done_s   = out_fire_s && (bit_idx_r == LAST_IDX);
        nxt_idx_s    = bit_idx_r + PTRW'(1);
        surv_bit_s   = surv_mem_r[t_ptr_r][cur_state_r];
    end

    // Next-state logic for the FILL -> TRACE -> OUTPUT cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL: begin
                if (fill_done_s) state_s = TRACE;
                else             state_s = FILL;
            end
            TRACE: begin
                if (trace_done_s) state_s = OUTPUT;
                else              state_s = TRACE;
            end
            OUTPUT: begin
                if (out_done_s) state_s = FILL;
                else            state_s = OUTPUT;
            end
            default: state_s = FILL;
        endcase
    end

    // State register, pointers, trellis state and registered output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= FILL;
            wr_ptr_r    <= {PTRW{1'b0}};
            t_ptr_r     <= {PTRW{1'b0}};
            bit_idx_r   <= {PTRW{1'b0}};
            cur_state_r <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == FILL);
            case (state_r)
                FILL: begin
                    if (fill_done_s) begin
                        wr_ptr_r    <= {PTRW{1'b0}};
                        t_ptr_r     <= LAST_IDX;
                        cur_state_r <= min_lane(pm_i);
                    end else if (wr_fire_s) begin
                        wr_ptr_r <= wr_ptr_r + PTRW'(1);
                    end
                end
                TRACE: begin
                    cur_state_r <= {cur_state_r[0], surv_bit_s};
                    if (trace_done_s) t_ptr_r <= {PTRW{1'b0}};
                    else              t_ptr_r <= t_ptr_r - PTRW'(1);
                end
                OUTPUT: begin
                    // First OUTPUT cycle primes the output register from buffer index 0.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_bit_r   <= out_buf_r[0];
                        out_last_r  <= (LAST_IDX == {PTRW{1'b0}});
                    end else if (out_done_s) begin
                        out_valid_r <= 1'b0;
                        out_bit_r   <= 1'b0;
                        out_last_r  <= 1'b0;
                        bit_idx_r   <= {PTRW{1'b0}};
                    end else if (out_fire_s) begin
                        bit_idx_r   <= nxt_idx_s;
                        out_bit_r   <= out_buf_r[nxt_idx_s];
                        out_last_r  <= (nxt_idx_s == LAST_IDX);
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Survivor memory and decoded-bit buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) surv_mem_r[wr_ptr_r] <= sel_i;
        if (state_r == TRACE) out_buf_r[t_ptr_r] <= cur_state_r[1];
    end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed self-checking bench for traceback_unit (DEPTH=16, PMW=8).
module tb_traceback_unit;

    localparam int DEPTH = 16;
    localparam int PMW   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_i;
    logic [3:0]       sel_i;
    logic [4*PMW-1:0] pm_i;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_ready;
    logic             out_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]       blk_sel [DEPTH];
    logic [4*PMW-1:0] blk_pm_last;
    logic [DEPTH-1:0] seq_exp;

    traceback_unit #(.DEPTH(DEPTH), .PMW(PMW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sel_i(sel_i), .pm_i(pm_i),
        .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit),
        .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4*PMW-1:0] lanes(input int a0, input int a1, input int a2, input int a3);
        return {PMW'(a3), PMW'(a2), PMW'(a1), PMW'(a0)};
    endfunction

    task automatic feed_steps();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL feed_ready step %0d: got %b expected 1", i, in_ready);
            end
            valid_i = 1'b1;
            sel_i   = blk_sel[i];
            pm_i    = (i == DEPTH-1) ? blk_pm_last : lanes(1, 1, 1, 1);
        end
        @(negedge clk);
        valid_i = 1'b0;
        sel_i   = 4'b0000;
    endtask

    task automatic wait_valid(input bit keep_valid, output int lat);
        bit ready_bad;
        ready_bad = 1'b0;
        lat = 0;
        valid_i = keep_valid;
        sel_i   = keep_valid ? 4'b1010 : 4'b0000;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) ready_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        valid_i = 1'b0;
        sel_i   = 4'b0000;
        n_checks++;
        if (ready_bad) begin
            n_fail++;
            $display("FAIL busy_in_ready: got 1 while tracing, expected 0");
        end
    endtask

    task automatic collect(input int stall_at, output logic [DEPTH-1:0] bits);
        int  i;
        int  guard;
        logic b0;
        logic l0;
        logic exp_last;
        i = 0;
        guard = 0;
        bits = '0;
        while (i < DEPTH && guard < 200) begin
            if (out_valid === 1'b1) begin
                if (i == stall_at) begin
                    b0 = out_bit;
                    l0 = out_last;
                    out_ready = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        n_checks++;
                        if (out_valid !== 1'b1 || out_bit !== b0 || out_last !== l0 || in_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL stall_hold cycle %0d: got v=%b b=%b l=%b r=%b expected v=1 b=%b l=%b r=0",
                                     k, out_valid, out_bit, out_last, in_ready, b0, l0);
                        end
                    end
                    out_ready = 1'b1;
                end
                bits[i]  = out_bit;
                exp_last = (i == DEPTH-1);
                n_checks++;
                if (out_last !== exp_last) begin
                    n_fail++;
                    $display("FAIL out_last bit %0d: got %b expected %b", i, out_last, exp_last);
                end
                i++;
            end
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (i != DEPTH) begin
            n_fail++;
            $display("FAIL collect_count: got %0d bits expected %0d", i, DEPTH);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL return_fill: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic run_block(input string name, input int stall_at, input bit keep_valid,
                             input logic [DEPTH-1:0] exp);
        int lat;
        logic [DEPTH-1:0] bits;
        feed_steps();
        wait_valid(keep_valid, lat);
        n_checks++;
        if (lat != DEPTH + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, DEPTH + 1);
        end
        collect(stall_at, bits);
        n_checks++;
        if (bits !== exp) begin
            n_fail++;
            $display("FAIL %s bits: got %h expected %h", name, bits, exp);
        end
    endtask

    task automatic load_uniform(input logic [3:0] s, input logic [4*PMW-1:0] pm_last);
        for (int i = 0; i < DEPTH; i++) blk_sel[i] = s;
        blk_pm_last = pm_last;
    endtask

    // Survivors encoding u = 1,0,1,1,0,0,1,0 repeated; off-path lanes hold the opposite bit.
    task automatic load_sequence();
        int seq [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        int u0, u1, u2, s;
        for (int t = 0; t < DEPTH; t++) begin
            u0 = seq[t % 8];
            u1 = (t >= 1) ? seq[(t-1) % 8] : 0;
            u2 = (t >= 2) ? seq[(t-2) % 8] : 0;
            s  = u0 * 2 + u1;
            blk_sel[t]    = (u2 != 0) ? 4'b0000 : 4'b1111;
            blk_sel[t][s] = (u2 != 0);
            seq_exp[t]    = (u0 != 0);
        end
        s = seq[(DEPTH-1) % 8] * 2 + seq[(DEPTH-2) % 8];
        blk_pm_last = lanes(s == 0 ? 3 : 10, s == 1 ? 3 : 10, s == 2 ? 3 : 10, s == 3 ? 3 : 10);
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_i = 1'b0; sel_i = 4'b0000; pm_i = '0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b b=%b l=%b expected 0/0/0", out_valid, out_bit, out_last);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_zeros();
        load_uniform(4'b0000, lanes(0, 5, 5, 5));
        run_block("zeros", -1, 1'b1, 16'h0000);
    endtask

    task automatic test_ones();
        load_uniform(4'b1111, lanes(9, 9, 9, 2));
        run_block("ones", -1, 1'b0, 16'hFFFF);
    endtask

    task automatic test_tie();
        load_uniform(4'b1111, lanes(7, 7, 7, 7));
        run_block("tie", -1, 1'b0, 16'h3FFF);
    endtask

    task automatic test_sequence();
        load_sequence();
        run_block("sequence", -1, 1'b0, seq_exp);
    endtask

    task automatic test_backpressure();
        load_sequence();
        run_block("backpressure", 3, 1'b0, seq_exp);
    endtask

    task automatic test_reset_mid_block();
        // Partial fill abandoned by reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = 1'b1; sel_i = 4'b0101; pm_i = lanes(1, 1, 1, 1);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load_sequence();
        run_block("after_fill_reset", -1, 1'b0, seq_exp);
        // Reset during the eighth TRACE cycle.
        load_uniform(4'b1111, lanes(9, 9, 9, 2));
        feed_steps();
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trace_reset_valid: got %b expected 0", out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trace_reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        load_sequence();
        run_block("after_trace_reset", -1, 1'b0, seq_exp);
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_ones();
        test_tie();
        test_sequence();
        test_backpressure();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 Parameter DEPTH, default 16, trellis steps per decode block; legal range 4..64.
REQ-002 Parameter PMW, default 8, path-metric width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  1  sel_i and pm_i carry one trellis step.
REQ-006 sel_i  input  4  ACS selection bit per state; bit s belongs to state s.
REQ-007 pm_i  input  4*PMW  ACS path cost per state; state s occupies bits [s*PMW +: PMW].
REQ-008 in_ready  output  1  block accepts a trellis step this cycle.
REQ-009 out_valid  output  1  out_bit holds a decoded bit.
REQ-010 out_bit  output  1  decoded bit.
REQ-011 out_ready  input  1  downstream accepts out_bit.
REQ-012 out_last  output  1  out_bit is the final bit of the block; qualified by out_valid.

Function
REQ-013 The FSM SHALL have three states, FILL, TRACE and OUTPUT, and SHALL enter FILL on reset.
REQ-014 in_ready SHALL be 1 only in FILL; out_valid SHALL be 1 only in OUTPUT.
REQ-015 In FILL, each cycle with valid_i=1 SHALL write sel_i to survivor memory at wr_ptr and increment wr_ptr; valid_i=0 SHALL write nothing.
REQ-016 valid_i while in_ready=0 SHALL be ignored, with no write and no state change.
REQ-017 On the write at wr_ptr=DEPTH-1, the block SHALL latch start_state = index of the minimum pm_i lane, unsigned compare, ties to the lowest index; it SHALL then clear wr_ptr and move to TRACE.
REQ-018 The state encoding SHALL be s={u_t,u_t-1}. Decoded bit for step t = s[1]; predecessor = {s[0], mem[t][s]}.
REQ-019 TRACE SHALL process one step per cycle, from t=DEPTH-1 down to 0.
REQ-020 Each TRACE cycle SHALL write s[1] into output buffer index t and update s to its predecessor.
REQ-021 After t=0, TRACE SHALL move to OUTPUT; TRACE SHALL last exactly DEPTH cycles.
REQ-022 Latency: if the final step is accepted at edge T, out_valid SHALL first be 1 after edge T+DEPTH+1.
REQ-023 OUTPUT SHALL present buffer bits in forward order, index 0 first.
REQ-024 A bit SHALL advance only on a cycle with out_valid=1 and out_ready=1; out_bit and out_last SHALL hold stable while out_ready=0.
REQ-025 out_last SHALL be 1 for index DEPTH-1 only.
REQ-026 Acceptance of the last bit SHALL return the FSM to FILL, with in_ready=1 in the next cycle.
REQ-027 No input SHALL be accepted during TRACE or OUTPUT; there is no overlap between blocks.
REQ-028 Pointers and the bit index SHALL never wrap past DEPTH-1; each SHALL be cleared explicitly at its state exit.

Reset
REQ-029 rst=0 SHALL immediately force: FSM=FILL, wr_ptr=0, bit index=0, start_state=0, out_valid=0, out_bit=0, out_last=0.
REQ-030 in_ready SHALL be 1 once rst=1.
REQ-031 Survivor memory and output buffer contents need not be cleared.
REQ-032 Reset asserted in any state, mid-TRACE or mid-OUTPUT included, SHALL abandon the partial block; the next accepted step SHALL be written at index 0.

Verification
REQ-033 DEPTH=16, 16 steps of sel_i=4'b0000 and pm_i lanes {0,5,5,5} with out_ready=1 -> 16 bits of 0; out_last on bit 16; first out_valid 17 cycles after the final input edge.
REQ-034 16 steps of sel_i=4'b1111 and lanes {9,9,9,2} -> start_state=3; 16 bits of 1.
REQ-035 Last step with all four lanes equal to 7 -> start_state=0.
REQ-036 Hand-built survivor memory encoding the input sequence 1,0,1,1,0,0,1,0,... (16 steps) with the minimum lane at the true final state -> output equals the sequence in order.
REQ-037 out_ready held 0 for 5 cycles at bit 3 -> out_bit and out_last stable for those 5 cycles; no bit lost or duplicated; in_ready stays 0.
REQ-038 rst pulsed low during TRACE cycle 8 -> out_valid=0 and in_ready=1 after release; the next 16-step block decodes correctly from index 0.
